// File: rtl/div_seq_ctrl_if.sv
// Signal bundle around div_seq_ctrl: pipeline request, divider handshake and HI/LO write port.
// master = surrounding pipeline/divider/HI-LO logic, slave = the controller.
interface div_seq_ctrl_if;
    logic        req_valid;
    logic        req_unsigned;
    logic [31:0] req_op1;
    logic [31:0] req_op2;
    logic        flush;
    logic        stall_o;
    logic        div_start;
    logic        div_unsigned;
    logic [31:0] div_op1;
    logic [31:0] div_op2;
    logic [63:0] div_result;
    logic        div_done;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] hi_o;
    logic [31:0] lo_o;
    logic        busy;
    logic        wdog_err;

    modport master (
        output req_valid, req_unsigned, req_op1, req_op2, flush,
               div_result, div_done, res_ready,
        input  stall_o, div_start, div_unsigned, div_op1, div_op2,
               res_valid, hi_o, lo_o, busy, wdog_err
    );

    modport slave (
        input  req_valid, req_unsigned, req_op1, req_op2, flush,
               div_result, div_done, res_ready,
        output stall_o, div_start, div_unsigned, div_op1, div_op2,
               res_valid, hi_o, lo_o, busy, wdog_err
    );
endinterface

// File: rtl/div_seq_ctrl.sv
// Sequencer for the iterative 32-bit divider: latches operands, drives level start, stalls until HI/LO write.
// Optional macro DIV_ZERO_FAST_EN: zero divisor skips the divider (hi=op1, lo=all ones).
module div_seq_ctrl #(
    parameter int DIV_CYCLES = 36,
    parameter int WDOG_SLACK = 8
) (
    input  logic          clock,
    input  logic          reset,
    div_seq_ctrl_if.slave bus
);
    localparam int WDOG_LIMIT = DIV_CYCLES + WDOG_SLACK;
    localparam int CNT_W      = $clog2(WDOG_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WDOG_LIMIT - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE, COOL} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] wdog_cnt_q, wdog_cnt_d;
    logic             div_start_q, div_start_d;
    logic             div_unsigned_q, div_unsigned_d;
    logic [31:0]      div_op1_q, div_op1_d;
    logic [31:0]      div_op2_q, div_op2_d;
    logic [31:0]      hi_q, hi_d;
    logic [31:0]      lo_q, lo_d;
    logic             wdog_err_q, wdog_err_d;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q        <= IDLE;
            wdog_cnt_q     <= '0;
            div_start_q    <= 1'b0;
            div_unsigned_q <= 1'b0;
            div_op1_q      <= '0;
            div_op2_q      <= '0;
            hi_q           <= '0;
            lo_q           <= '0;
            wdog_err_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            wdog_cnt_q     <= wdog_cnt_d;
            div_start_q    <= div_start_d;
            div_unsigned_q <= div_unsigned_d;
            div_op1_q      <= div_op1_d;
            div_op2_q      <= div_op2_d;
            hi_q           <= hi_d;
            lo_q           <= lo_d;
            wdog_err_q     <= wdog_err_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        wdog_cnt_d     = wdog_cnt_q;
        div_unsigned_d = div_unsigned_q;
        div_op1_d      = div_op1_q;
        div_op2_d      = div_op2_q;
        hi_d           = hi_q;
        lo_d           = lo_q;
        wdog_err_d     = wdog_err_q;

        // Flush wins over everything and leaves HI/LO and operands untouched.
        if (bus.flush) begin
            state_d = COOL;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.req_valid) begin
                        div_unsigned_d = bus.req_unsigned;
                        div_op1_d      = bus.req_op1;
                        div_op2_d      = bus.req_op2;
                        wdog_cnt_d     = '0;
`ifdef DIV_ZERO_FAST_EN
                        if (bus.req_op2 == 32'h0) begin
                            hi_d    = bus.req_op1;
                            lo_d    = 32'hFFFF_FFFF;
                            state_d = DONE;
                        end else begin
                            state_d = RUN;
                        end
`else
                        state_d = RUN;
`endif
                    end
                end
                RUN: begin
                    if (bus.div_done) begin
                        hi_d    = bus.div_result[63:32];
                        lo_d    = bus.div_result[31:0];
                        state_d = DONE;
                    end else if (wdog_cnt_q == CNT_LAST) begin
                        // Last permitted start cycle elapsed without completion.
                        wdog_err_d = 1'b1;
                        hi_d       = '0;
                        lo_d       = '0;
                        state_d    = DONE;
                    end else begin
                        wdog_cnt_d = wdog_cnt_q + CNT_W'(1);
                    end
                end
                DONE: begin
                    if (bus.res_ready) begin
                        state_d = COOL;
                    end
                end
                COOL: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        // Start is registered from the next state so it is high exactly while in RUN.
        div_start_d = (state_d == RUN);
    end

    assign bus.div_start    = div_start_q;
    assign bus.div_unsigned = div_unsigned_q;
    assign bus.div_op1      = div_op1_q;
    assign bus.div_op2      = div_op2_q;
    assign bus.hi_o         = hi_q;
    assign bus.lo_o         = lo_q;
    assign bus.wdog_err     = wdog_err_q;
    assign bus.busy         = (state_q != IDLE);
    assign bus.res_valid    = (state_q == DONE) && !bus.flush;
    assign bus.stall_o      = bus.req_valid && !bus.flush &&
                              !((state_q == DONE) && bus.res_ready);
endmodule
